// File: rtl/mem_port_arbiter_if.sv
// Bundle of the I-fetch, D-access and memory-side signals around mem_port_arbiter.
// slave = the arbiter's view; master = the requesters plus the memory.
interface mem_port_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous-read memory between instruction fetch (I) and data access (D).
// D wins contention unless I has already lost MAXD times in a row; read data returns one cycle after grant.
module mem_port_arbiter #(
  parameter int AW   = 9,
  parameter int DW   = 32,
  parameter int MAXD = 3,
  parameter int CW   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   halt,
  mem_port_arbiter_if.slave      bus,
  output logic [CW-1:0]          conf_cnt
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam logic [3:0]    STREAK_MAX = 4'(MAXD);
  localparam logic [CW-1:0] CONF_MAX   = '1;
  localparam logic [AW-1:0] ADDR_ZERO  = '0;
  localparam logic [DW-1:0] DATA_ZERO  = '0;

  owner_t        r_owner;
  owner_t        w_owner_next;
  logic [3:0]    r_streak;
  logic [3:0]    w_streak_next;
  logic [CW-1:0] r_conf;
  logic [CW-1:0] w_conf_next;
  logic          w_i_gnt;
  logic          w_d_gnt;
  logic          w_conflict;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner  <= OWN_NONE;
      r_streak <= '0;
      r_conf   <= '0;
    end else begin
      r_owner  <= w_owner_next;
      r_streak <= w_streak_next;
      r_conf   <= w_conf_next;
    end
  end

  // Grant decision; the streak forces I through once D has won MAXD times in a row.
  always_comb begin
    w_i_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (!rst && !halt) begin
      if (bus.i_req && bus.d_req) begin
        if (r_streak == STREAK_MAX) begin
          w_i_gnt = 1'b1;
        end else begin
          w_d_gnt = 1'b1;
        end
      end else begin
        w_i_gnt = bus.i_req;
        w_d_gnt = bus.d_req;
      end
    end
  end

  always_comb begin
    w_owner_next = OWN_NONE;
    if (w_i_gnt) begin
      w_owner_next = OWN_I;
    end else if (w_d_gnt && !bus.d_we) begin
      w_owner_next = OWN_D;
    end
  end

  // A halted cycle with I still waiting leaves the streak untouched.
  always_comb begin
    w_streak_next = r_streak;
    if (w_i_gnt || !bus.i_req) begin
      w_streak_next = '0;
    end else if (w_d_gnt && (r_streak != STREAK_MAX)) begin
      w_streak_next = r_streak + 4'd1;
    end
  end

  assign w_conflict = bus.i_req && bus.d_req && !halt;

  always_comb begin
    w_conf_next = r_conf;
    if (w_conflict && (r_conf != CONF_MAX)) begin
      w_conf_next = r_conf + 1'b1;
    end
  end

  assign bus.i_gnt   = w_i_gnt;
  assign bus.d_gnt   = w_d_gnt;
  assign bus.m_en    = w_i_gnt | w_d_gnt;
  assign bus.m_we    = w_d_gnt & bus.d_we;
  assign bus.m_addr  = w_d_gnt ? bus.d_addr : (w_i_gnt ? bus.i_addr : ADDR_ZERO);
  assign bus.m_wdata = w_d_gnt ? bus.d_wdata : DATA_ZERO;

  // A read still in flight while rst is high is dropped rather than delivered.
  assign bus.i_rvalid = (r_owner == OWN_I) && !rst;
  assign bus.d_rvalid = (r_owner == OWN_D) && !rst;
  assign bus.i_rdata  = bus.i_rvalid ? bus.m_rdata : DATA_ZERO;
  assign bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : DATA_ZERO;

  assign conf_cnt = r_conf;

endmodule
